// File: rtl/ltl_report_collector.sv
// Samples an ltl2cN automaton's report wires once per consumed symbol, queues
// timestamped events, and keeps saturating hit counters plus sticky flags.
// Define LTL_REPORT_EDGE_EN to record only rising reports instead of levels.
module ltl_report_collector #(
    parameter int NUM_REPORTS = 4,
    parameter int FIFO_DEPTH  = 8,
    parameter int TS_WIDTH    = 32,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             run_i,
    input  logic                             flush_i,
    input  logic [NUM_REPORTS-1:0]           report_i,
    output logic                             evt_valid_o,
    input  logic                             evt_ready_i,
    output logic [NUM_REPORTS-1:0]           evt_mask_o,
    output logic [TS_WIDTH-1:0]              evt_ts_o,
    output logic [$clog2(FIFO_DEPTH):0]      level_o,
    output logic [NUM_REPORTS*CNT_WIDTH-1:0] hit_cnt_o,
    output logic                             violation_o,
    output logic                             overflow_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic                   run_q, run_d;
    logic [TS_WIDTH-1:0]    sym_idx_q, sym_idx_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]       level_q, level_d;
    logic [NUM_REPORTS-1:0] mem_mask_q [FIFO_DEPTH];
    logic [NUM_REPORTS-1:0] mem_mask_d [FIFO_DEPTH];
    logic [TS_WIDTH-1:0]    mem_ts_q   [FIFO_DEPTH];
    logic [TS_WIDTH-1:0]    mem_ts_d   [FIFO_DEPTH];
    logic [CNT_WIDTH-1:0]   hit_cnt_q  [NUM_REPORTS];
    logic [CNT_WIDTH-1:0]   hit_cnt_d  [NUM_REPORTS];
    logic                   violation_q, violation_d;
    logic                   overflow_q, overflow_d;
`ifdef LTL_REPORT_EDGE_EN
    logic [NUM_REPORTS-1:0] report_prev_q, report_prev_d;
`endif

    logic                   sample;
    logic                   push;
    logic                   pop;
    logic                   full;
    logic                   push_ok;
    logic [NUM_REPORTS-1:0] mask;

    always_comb begin
        sample = run_q & ~flush_i;
`ifdef LTL_REPORT_EDGE_EN
        mask   = report_i & ~report_prev_q;
`else
        mask   = report_i;
`endif
        push    = sample & (|mask);
        pop     = (level_q != '0) & evt_ready_i;
        full    = (level_q == LVL_W'(FIFO_DEPTH));
        push_ok = push & (~full | pop);

        run_d       = run_q;
        sym_idx_d   = sym_idx_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        mem_mask_d  = mem_mask_q;
        mem_ts_d    = mem_ts_q;
        hit_cnt_d   = hit_cnt_q;
        violation_d = violation_q;
        overflow_d  = overflow_q;
`ifdef LTL_REPORT_EDGE_EN
        report_prev_d = report_prev_q;
`endif

        if (flush_i) begin
            run_d       = 1'b0;
            sym_idx_d   = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            violation_d = 1'b0;
            overflow_d  = 1'b0;
            for (int r = 0; r < NUM_REPORTS; r++) begin
                hit_cnt_d[r] = '0;
            end
`ifdef LTL_REPORT_EDGE_EN
            report_prev_d = '0;
`endif
        end else begin
            run_d = run_i;
            if (run_i) begin
                sym_idx_d = sym_idx_q + TS_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            // The sample belongs to the symbol consumed last cycle, whose index is one behind.
            if (push_ok) begin
                mem_mask_d[wr_ptr_q] = mask;
                mem_ts_d[wr_ptr_q]   = sym_idx_q - TS_WIDTH'(1);
                wr_ptr_d             = wr_ptr_q + PTR_W'(1);
            end else if (push) begin
                overflow_d = 1'b1;
            end
            level_d = level_q + LVL_W'(push_ok) - LVL_W'(pop);
            if (sample) begin
                for (int r = 0; r < NUM_REPORTS; r++) begin
                    if (mask[r] && (hit_cnt_q[r] != '1)) begin
                        hit_cnt_d[r] = hit_cnt_q[r] + CNT_WIDTH'(1);
                    end
                end
                if (report_i != '0) begin
                    violation_d = 1'b1;
                end
`ifdef LTL_REPORT_EDGE_EN
                report_prev_d = report_i;
`endif
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_q       <= 1'b0;
            sym_idx_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            violation_q <= 1'b0;
            overflow_q  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_mask_q[i] <= '0;
                mem_ts_q[i]   <= '0;
            end
            for (int r = 0; r < NUM_REPORTS; r++) begin
                hit_cnt_q[r] <= '0;
            end
`ifdef LTL_REPORT_EDGE_EN
            report_prev_q <= '0;
`endif
        end else begin
            run_q       <= run_d;
            sym_idx_q   <= sym_idx_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            violation_q <= violation_d;
            overflow_q  <= overflow_d;
            mem_mask_q  <= mem_mask_d;
            mem_ts_q    <= mem_ts_d;
            hit_cnt_q   <= hit_cnt_d;
`ifdef LTL_REPORT_EDGE_EN
            report_prev_q <= report_prev_d;
`endif
        end
    end

    // Head data is forced to zero while empty so stale entries never leak out.
    always_comb begin
        evt_valid_o = (level_q != '0);
        evt_mask_o  = evt_valid_o ? mem_mask_q[rd_ptr_q] : '0;
        evt_ts_o    = evt_valid_o ? mem_ts_q[rd_ptr_q] : '0;
        level_o     = level_q;
        violation_o = violation_q;
        overflow_o  = overflow_q;
        hit_cnt_o   = '0;
        for (int r = 0; r < NUM_REPORTS; r++) begin
            hit_cnt_o[r*CNT_WIDTH +: CNT_WIDTH] = hit_cnt_q[r];
        end
    end

endmodule
